// File: rtl/from_mont_halve.sv
// Montgomery-domain exit: result = X * 2^-HALVE_STEPS mod M via repeated modular halving.
// Optional macro FROM_MONT_STATE_OUT_EN exposes the FSM state on port state_out.
module from_mont_halve #(
  parameter int INPUT_WIDTH = 1024,
  parameter int HALVE_STEPS = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] in_x,
  input  logic [INPUT_WIDTH-1:0] in_m,
  output logic [INPUT_WIDTH-1:0] result,
  output logic                   busy,
  output logic                   done
`ifdef FROM_MONT_STATE_OUT_EN
  ,
  output logic [1:0]             state_out
`endif
);

  localparam int CW = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HALVE   = 2'd1,
    ST_CORRECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INPUT_WIDTH:0]   r_acc;
  logic [INPUT_WIDTH-1:0] r_m;
  logic [CW-1:0]          r_cnt;
  logic [INPUT_WIDTH-1:0] r_result;
  logic                   r_done;

  logic [INPUT_WIDTH-1:0] w_addend;
  logic [INPUT_WIDTH+1:0] w_sum;
  logic [INPUT_WIDTH:0]   w_halved;
  logic                   w_sum_lsb_unused;
  logic                   w_ge;
  logic [INPUT_WIDTH-1:0] w_corr;
  logic                   w_last;

  // Adding M to an odd accumulator makes it even; one extra sum bit keeps the carry.
  assign w_addend         = r_acc[0] ? r_m : {INPUT_WIDTH{1'b0}};
  assign w_sum            = {1'b0, r_acc} + {2'b00, w_addend};
  assign w_halved         = w_sum[INPUT_WIDTH+1:1];
  assign w_sum_lsb_unused = w_sum[0];

  // acc < 2M, so a single conditional subtraction lands in [0, M).
  assign w_ge   = (r_acc >= {1'b0, r_m});
  assign w_corr = w_ge ? (r_acc[INPUT_WIDTH-1:0] - r_m) : r_acc[INPUT_WIDTH-1:0];
  assign w_last = (r_cnt == CW'(HALVE_STEPS - 1));

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_HALVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALVE: begin
        if (w_last) begin
          w_state_nxt = ST_CORRECT;
        end else begin
          w_state_nxt = ST_HALVE;
        end
      end
      ST_CORRECT: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, halving steps, final correction and done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc    <= {(INPUT_WIDTH+1){1'b0}};
      r_m      <= {INPUT_WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_result <= {INPUT_WIDTH{1'b0}};
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc <= {1'b0, in_x};
            r_m   <= in_m;
            r_cnt <= {CW{1'b0}};
          end
        end
        ST_HALVE: begin
          r_acc <= w_halved;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_CORRECT: begin
          r_result <= w_corr;
          r_done   <= 1'b1;
        end
        ST_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state == ST_HALVE) || (r_state == ST_CORRECT);

`ifdef FROM_MONT_STATE_OUT_EN
  assign state_out = r_state;
`endif

endmodule

// File: tb/tb_from_mont_halve.sv
// Bench for from_mont_halve: 8-bit instance checked every cycle against a behavioural
// model, plus directed runs on a default-parameter (1024-bit) instance.
`timescale 1ns/1ps
module tb_from_mont_halve;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int BW = 1024;
  localparam int BH = 1024;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] in_x = '0, in_m = '0, result;
  logic         busy, done;

  logic          b_start = 1'b0;
  logic [BW-1:0] b_x = '0, b_m = '0, b_result;
  logic          b_busy, b_done;

`ifdef FROM_MONT_STATE_OUT_EN
  logic [1:0] state_out, b_state_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  from_mont_halve #(.INPUT_WIDTH(W), .HALVE_STEPS(H)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_m(in_m),
    .result(result), .busy(busy), .done(done)
`ifdef FROM_MONT_STATE_OUT_EN
    , .state_out(state_out)
`endif
  );

  from_mont_halve u_big (
    .clk(clk), .resetn(resetn), .start(b_start), .in_x(b_x), .in_m(b_m),
    .result(b_result), .busy(b_busy), .done(b_done)
`ifdef FROM_MONT_STATE_OUT_EN
    , .state_out(b_state_out)
`endif
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (low 128b) at %0t", name, act[127:0], exp[127:0], $time);
    end
  endtask

  // Reference: X * (2^-1)^H mod M, with 2^-1 = (M+1)/2 for odd M.
  function automatic logic [W-1:0] ref_small(input int x, input int m);
    longint r, inv2;
    if (m == 0) return '0;
    inv2 = (m + 1) / 2;
    r = x % m;
    for (int i = 0; i < H; i++) r = (r * inv2) % m;
    return W'(r);
  endfunction

  function automatic logic [BW-1:0] ref_big(input logic [BW-1:0] x, input logic [BW-1:0] m);
    logic [2*BW-1:0] r, inv2, mm;
    mm   = {{BW{1'b0}}, m};
    inv2 = (mm + 1) >> 1;
    r    = {{BW{1'b0}}, x} % mm;
    for (int i = 0; i < BH; i++) r = (r * inv2) % mm;
    return r[BW-1:0];
  endfunction

  // Behavioural timeline: m_k counts edges since the accepting edge.
  logic         m_active = 1'b0;
  int           m_k = 0;
  int           m_ndone = 0;
  logic [W-1:0] m_pend = '0, m_result = '0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_result <= '0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k == H) begin
        m_result <= m_pend;
        m_ndone  <= m_ndone + 1;
      end
      if (m_k == H + 1) m_active <= 1'b0;
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_pend   <= ref_small(int'(in_x), int'(in_m));
    end
  end

  logic exp_busy, exp_done;
  logic [1:0] exp_state;
  always_comb begin
    exp_busy  = m_active && (m_k <= H);
    exp_done  = m_active && (m_k == H + 1);
    exp_state = !m_active ? 2'd0 : (m_k < H) ? 2'd1 : (m_k == H) ? 2'd2 : 2'd3;
  end

  int d_cnt = 0;
  // Per-cycle compare of the 8-bit instance against the model
  always @(negedge clk) begin
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("result", result, m_result);
`ifdef FROM_MONT_STATE_OUT_EN
    check("state_out", state_out, exp_state);
`endif
    if (done) d_cnt++;
  end

  task automatic conv_small(input int x, input int m, input bit disturb);
    int n;
    @(negedge clk);
    in_x = W'(x); in_m = W'(m); start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < H + 10) begin
      start = disturb && (n == 3 || n == H + 1);
      if (start) begin in_x = W'($urandom); in_m = W'($urandom | 1); end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, H + 2);
  endtask

  task automatic conv_big(input logic [BW-1:0] x, input logic [BW-1:0] m);
    int n;
    @(negedge clk);
    b_x = x; b_m = m; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_x = '0;
    n = 1;
    while (!b_done && n < BH + 20) begin
      @(negedge clk);
      n++;
    end
    check("big_latency", n, BH + 2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, dn, cyc, target, m, xmax;
    logic [BW-1:0] bm, bx, br;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 resetn = 1'b1;

    conv_small(9, 13, 1'b0);  check("x9_m13", result, 1);
    conv_small(18, 13, 1'b0); check("x18_m13", result, 2);
    conv_small(5, 13, 1'b0);  check("x5_m13", result, 2);
    conv_small(0, 13, 1'b0);  check("x0_m13", result, 0);
    conv_small(13, 13, 1'b0); check("xM_m13", result, 0);
    conv_small(9, 13, 1'b1);  check("ignored_start", result, 1);

    // Abort mid-conversion with reset
    @(negedge clk);
    in_x = 8'd7; in_m = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    @(negedge clk);
    check("abort_result", result, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    #2 resetn = 1'b1;
    dn = 0;
    repeat (H + 4) begin @(negedge clk); if (done) dn++; end
    check("abort_no_done", dn, 0);
    conv_small(9, 13, 1'b0);  check("after_abort", result, 1);

    // Random stream; start high 75% of cycles also exercises held start
    target = m_ndone + 1000;
    cyc = 0;
    while (m_ndone < target && cyc < 40000) begin
      @(negedge clk);
      m = 2 * $urandom_range(1, 127) + 1;
      xmax = (2 * m - 1 > 255) ? 255 : 2 * m - 1;
      in_m = W'(m);
      in_x = W'($urandom_range(0, xmax));
      start = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    start = 1'b0;
    check("rand_complete", m_ndone >= target, 1);
    repeat (H + 4) @(negedge clk);
    check("done_count", d_cnt, m_ndone);

    // Default-parameter instance, M = 2^1023 + 1, 2^1024 mod M = M - 2
    bm = '0; bm[BW-1] = 1'b1; bm[0] = 1'b1;
    conv_big(bm - 2, bm);
    check("big_one", b_result, 1);
    conv_big('0, bm);
    check("big_zero", b_result, 0);
    for (int i = 0; i < BW / 32; i++) begin
      bm[i*32 +: 32] = $urandom;
      bx[i*32 +: 32] = $urandom;
    end
    bm[BW-1] = 1'b1; bm[0] = 1'b1;
    br = ref_big(bx, bm);
    conv_big(bx, bm);
    check("big_rand", b_result, br);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/from_mont_halve.md
FROM_MONT_HALVE -- requirements
Module: from_mont_halve

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 1024, operand width in bits.
REQ-002 SHALL have parameter HALVE_STEPS, default 1024, number of modular halvings (log2 R); legal range 1..4095.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin a conversion, sampled on rising clk.
REQ-006 SHALL have port in_x  input  INPUT_WIDTH  Montgomery-domain operand X, legal range 0 <= X < 2M.
REQ-007 SHALL have port in_m  input  INPUT_WIDTH  modulus M, odd, M >= 3.
REQ-008 SHALL have port result  output  INPUT_WIDTH  X * 2^-HALVE_STEPS mod M, registered.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port done  output  1  registered single-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, HALVE, CORRECT, DONE; no other reachable states; unreachable encodings return to IDLE.
REQ-012 In IDLE with start=1 at edge 0, SHALL load acc <= {1'b0, in_x}, regM <= in_m, step counter <= 0, and go to HALVE.
REQ-013 In IDLE with start=0, SHALL hold acc, regM and result unchanged.
REQ-014 In HALVE, each edge SHALL apply: if acc[0]=0 then acc <= acc >> 1, else acc <= (acc + regM) >> 1, sum formed at INPUT_WIDTH+1 bits so no carry is lost.
REQ-015 acc SHALL be INPUT_WIDTH+1 bits wide; invariant acc < 2M holds throughout HALVE.
REQ-016 The step counter SHALL increment once per HALVE edge; after exactly HALVE_STEPS halvings (edges 1..HALVE_STEPS), FSM SHALL enter CORRECT.
REQ-017 In CORRECT, at edge HALVE_STEPS+1, SHALL set result <= (acc >= regM) ? acc - regM : acc (low INPUT_WIDTH bits), set done <= 1, and go to DONE.
REQ-018 In DONE, at the next edge, SHALL clear done and return to IDLE; done is therefore high for exactly one cycle.
REQ-019 Latency: done SHALL be high during the cycle following edge HALVE_STEPS+1 after start was sampled.
REQ-020 busy SHALL be combinationally high in HALVE and CORRECT, low in IDLE and DONE.
REQ-021 start asserted while busy or in DONE SHALL be ignored; it does not restart or extend the conversion.
REQ-022 A start held high continuously SHALL trigger a new conversion on the first IDLE edge after DONE.
REQ-023 result SHALL remain stable from the done pulse until the next CORRECT update; in_x/in_m changes after edge 0 SHALL not affect the running conversion.
REQ-024 X = 0 SHALL yield result 0; X = M SHALL yield result 0.

Reset
REQ-025 resetn low SHALL asynchronously force state IDLE, acc 0, regM 0, counter 0, result 0, done 0, busy 0.
REQ-026 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the block waits in IDLE for a new start.
REQ-027 Reset removal SHALL be treated as synchronous to clk by the integrator; the block adds no synchronizer.

Configuration
REQ-028 With macro FROM_MONT_STATE_OUT_EN defined, SHALL add port state_out  output  2  current FSM state (IDLE=0, HALVE=1, CORRECT=2, DONE=3), reset value 0.
REQ-029 Without FROM_MONT_STATE_OUT_EN, port state_out SHALL be absent; all other behaviour identical.

Verification
REQ-030 INPUT_WIDTH=8, HALVE_STEPS=8, M=13, X=9 (256 mod 13) -> result=1, done high in cycle after edge 9.
REQ-031 INPUT_WIDTH=8, HALVE_STEPS=8, M=13, X=18 (>=M, <2M) -> result equals that for X=5, namely 5*256^-1 mod 13 = 5*3 mod 13 = 2.
REQ-032 Default parameters, M=2^1023+1 style odd modulus, X=(2^1024 mod M) -> result=1; X=0 -> result=0.
REQ-033 start pulsed again at edge 3 of a running conversion -> ignored, single done pulse at original latency, result unchanged by second request.
REQ-034 resetn pulsed low at edge 4 of a conversion -> result=0, done never asserts, busy=0; fresh start afterwards completes correctly.
REQ-035 Random odd M and X<2M over 1000 runs, both macro settings -> result matches reference model X*2^-HALVE_STEPS mod M; state_out sequence 0,1..1,2,3,0 when enabled.
